// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants: FSM encoding and instruction geometry.
package fetch_pkg;

   localparam int unsigned STATE_W = 2;

   // IDLE: nothing outstanding, WAIT: one request outstanding,
   // DISCARD: outstanding response will be dropped.
   localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
   localparam logic [STATE_W-1:0] ST_WAIT    = 2'd1;
   localparam logic [STATE_W-1:0] ST_DISCARD = 2'd2;

   localparam int unsigned INSTRUCTION_BYTES = 4;
   localparam logic [31:0] NOP_INSTRUCTION   = 32'h0000_0013;

endpackage : fetch_pkg

// File: rtl/fetch_buffer_slot.sv
// One-entry skid slot holding an instruction and its PC while decode is stalled.
module fetch_buffer_slot #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned PC_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_i,
   input  logic              load_i,
   input  logic              drain_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [PC_W-1:0]   pc_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [PC_W-1:0]   pc_o
);

   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic [PC_W-1:0]   pc_q;

   // Slot register: clear (redirect) wins over load, load wins over drain.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         pc_q    <= '0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         pc_q    <= pc_i;
      end else if (drain_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign pc_o    = pc_q;

endmodule : fetch_buffer_slot

// File: rtl/instruction_fetch_controller.sv
// Fetch controller: owns the PC, runs the single-outstanding instruction
// memory handshake and holds the IF/ID instruction register.
module instruction_fetch_controller
   import fetch_pkg::*;
#(
   parameter int unsigned             ADDRESS_WIDTH     = 32,
   parameter int unsigned             INSTRUCTION_WIDTH = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC         = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         isPipelineStalled,
   input  logic                         isBranchTaken,
   input  logic [ADDRESS_WIDTH-1:0]     branchTargetAddress,
   output logic                         memoryRequestValid,
   output logic [ADDRESS_WIDTH-1:0]     memoryRequestAddress,
   input  logic                         memoryRequestReady,
   input  logic                         memoryResponseValid,
   input  logic [INSTRUCTION_WIDTH-1:0] memoryResponseData,
   output logic                         isInstructionMemoryBlocked,
   output logic [INSTRUCTION_WIDTH-1:0] fetchedInstruction,
   output logic [ADDRESS_WIDTH-1:0]     fetchedProgramCounter,
   output logic                         isFetchedInstructionValid
);

   logic [STATE_W-1:0]           state_q, state_d;
   logic [ADDRESS_WIDTH-1:0]     pc_q, pc_d;
   logic [ADDRESS_WIDTH-1:0]     outstanding_pc_q, outstanding_pc_d;
   logic                         out_valid_q, out_valid_d;
   logic [INSTRUCTION_WIDTH-1:0] out_instr_q, out_instr_d;
   logic [ADDRESS_WIDTH-1:0]     out_pc_q, out_pc_d;

   logic                         buf_valid;
   logic [INSTRUCTION_WIDTH-1:0] buf_data;
   logic [ADDRESS_WIDTH-1:0]     buf_pc;
   logic                         buf_load, buf_clear, buf_drain;

   logic consume, resp_taken, req_valid, accept;

   // Decode takes the held word; request only when the skid slot has room.
   assign consume    = out_valid_q & ~isPipelineStalled;
   assign resp_taken = memoryResponseValid & (state_q == ST_WAIT);
   assign req_valid  = (state_q == ST_IDLE) & ~buf_valid & ~isBranchTaken & ~reset;
   assign accept     = req_valid & memoryRequestReady;

   fetch_buffer_slot #(
      .DATA_W (INSTRUCTION_WIDTH),
      .PC_W   (ADDRESS_WIDTH)
   ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .clear_i (buf_clear),
      .load_i  (buf_load),
      .drain_i (buf_drain),
      .data_i  (memoryResponseData),
      .pc_i    (outstanding_pc_q),
      .valid_o (buf_valid),
      .data_o  (buf_data),
      .pc_o    (buf_pc)
   );

   // State and IF/ID registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         pc_q             <= RESET_PC;
         outstanding_pc_q <= '0;
         out_valid_q      <= 1'b0;
         out_instr_q      <= '0;
         out_pc_q         <= '0;
      end else begin
         state_q          <= state_d;
         pc_q             <= pc_d;
         outstanding_pc_q <= outstanding_pc_d;
         out_valid_q      <= out_valid_d;
         out_instr_q      <= out_instr_d;
         out_pc_q         <= out_pc_d;
      end
   end

   // Next state: redirect first, then handshake progress and output/slot steering.
   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      outstanding_pc_d = outstanding_pc_q;
      out_valid_d      = out_valid_q;
      out_instr_d      = out_instr_q;
      out_pc_d         = out_pc_q;
      buf_load         = 1'b0;
      buf_clear        = 1'b0;
      buf_drain        = 1'b0;

      if (isBranchTaken) begin
         pc_d        = branchTargetAddress;
         out_valid_d = 1'b0;
         buf_clear   = 1'b1;
         case (state_q)
            ST_IDLE:    state_d = ST_IDLE;
            ST_WAIT,
            ST_DISCARD: state_d = memoryResponseValid ? ST_IDLE : ST_DISCARD;
            default:    state_d = ST_IDLE;
         endcase
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  outstanding_pc_d = pc_q;
                  pc_d             = pc_q + ADDRESS_WIDTH'(INSTRUCTION_BYTES);
                  state_d          = ST_WAIT;
               end
            end
            ST_WAIT,
            ST_DISCARD: begin
               if (memoryResponseValid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase

         if (consume && buf_valid) begin
            out_valid_d = 1'b1;
            out_instr_d = buf_data;
            out_pc_d    = buf_pc;
            buf_drain   = 1'b1;
         end else if (resp_taken && !buf_valid && (!out_valid_q || consume)) begin
            out_valid_d = 1'b1;
            out_instr_d = memoryResponseData;
            out_pc_d    = outstanding_pc_q;
         end else if (resp_taken) begin
            buf_load = 1'b1;
         end else if (consume) begin
            out_valid_d = 1'b0;
         end
      end
   end

   assign memoryRequestValid         = req_valid;
   assign memoryRequestAddress       = pc_q;
   assign isInstructionMemoryBlocked = ~out_valid_q;
   assign fetchedInstruction         = out_instr_q;
   assign fetchedProgramCounter      = out_pc_q;
   assign isFetchedInstructionValid  = out_valid_q;

endmodule : instruction_fetch_controller

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: memory responder plus a
// program-order stream model of what decode and memory must observe.
module tb_instruction_fetch_controller;
   import fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset, stall, br, rdy, rvalid;
   logic [31:0] tgt, rdata;
   logic        req_valid, blocked, fvalid;
   logic [31:0] req_addr, finstr, fpc;

   always #5 clk = ~clk;

   instruction_fetch_controller #(
      .ADDRESS_WIDTH     (32),
      .INSTRUCTION_WIDTH (32),
      .RESET_PC          (RST_PC)
   ) dut (
      .clk                        (clk),
      .reset                      (reset),
      .isPipelineStalled          (stall),
      .isBranchTaken              (br),
      .branchTargetAddress        (tgt),
      .memoryRequestValid         (req_valid),
      .memoryRequestAddress       (req_addr),
      .memoryRequestReady         (rdy),
      .memoryResponseValid        (rvalid),
      .memoryResponseData         (rdata),
      .isInstructionMemoryBlocked (blocked),
      .fetchedInstruction         (finstr),
      .fetchedProgramCounter      (fpc),
      .isFetchedInstructionValid  (fvalid)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic        pend     = 1'b0;
   logic [31:0] pend_addr;
   int          pend_due;
   logic [31:0] exp_req  = RST_PC;
   logic [31:0] exp_pc   = RST_PC;
   logic        prev_hold = 1'b0;
   logic [31:0] prev_addr;
   logic        acc;
   logic [31:0] acc_addr;
   logic        s_rv, s_fv, s_blk;
   logic [31:0] s_ra, s_fpc, s_fi;

   // Instruction memory contents as a function of address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hAAAA_0001 ^ a;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs, sample outputs, check against the stream model.
   task automatic step(input logic r, input logic st, input logic b, input logic [31:0] t,
                       input logic rd, input int lat, input logic inj);
      logic resp_now;
      @(negedge clk);
      cyc++;
      reset    = r;
      stall    = st;
      br       = b;
      tgt      = t;
      rdy      = rd;
      resp_now = !r && pend && (pend_due <= cyc);
      rvalid   = resp_now || inj;
      rdata    = resp_now ? mem_word(pend_addr) : 32'hDEAD_BEEF;
      #1;
      s_rv  = req_valid;
      s_ra  = req_addr;
      s_fv  = fvalid;
      s_fpc = fpc;
      s_fi  = finstr;
      s_blk = blocked;
      acc   = 1'b0;
      if (r) begin
         check_eq("req_in_reset", 32'(s_rv), 32'd0);
         pend      = 1'b0;
         exp_req   = RST_PC;
         exp_pc    = RST_PC;
         prev_hold = 1'b0;
      end else begin
         if (prev_hold && !b) begin
            check_eq("req_hold_valid", 32'(s_rv), 32'd1);
            check_eq("req_hold_addr", s_ra, prev_addr);
         end
         if (b) check_eq("req_on_branch", 32'(s_rv), 32'd0);
         if (s_rv) check_eq("one_outstanding", 32'(pend), 32'd0);
         if (resp_now) pend = 1'b0;
         if (b) begin
            exp_req = t;
         end else if (s_rv && rd) begin
            acc      = 1'b1;
            acc_addr = s_ra;
            check_eq("req_addr", s_ra, exp_req);
            exp_req   = exp_req + 32'd4;
            pend      = 1'b1;
            pend_addr = s_ra;
            pend_due  = cyc + lat;
         end
         if (b) begin
            exp_pc = t;
         end else if (s_fv && !st) begin
            check_eq("consume_pc", s_fpc, exp_pc);
            check_eq("consume_instr", s_fi, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
         end
         prev_hold = s_rv && !rd;
         prev_addr = s_ra;
      end
   endtask

   initial begin
      logic        found;
      logic        seen10;
      logic [31:0] first_addr;
      reset = 1'b1; stall = 1'b0; br = 1'b0; tgt = '0; rdy = 1'b0;
      rvalid = 1'b0; rdata = '0;

      // Reset state.
      step(1, 0, 0, 0, 1, 1, 0);
      step(1, 0, 0, 0, 1, 1, 0);
      check_eq("rst_valid", 32'(s_fv), 32'd0);
      check_eq("rst_blocked", 32'(s_blk), 32'd1);
      check_eq("rst_instr", s_fi, 32'd0);
      check_eq("rst_pc", s_fpc, 32'd0);

      // First fetch with 1-cycle memory, then stall with a response pending.
      step(0, 0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 1, 1, 0);
      step(0, 1, 0, 0, 1, 1, 0);
      check_eq("first_valid", 32'(s_fv), 32'd1);
      check_eq("first_pc", s_fpc, 32'h0);
      check_eq("first_instr", s_fi, 32'hAAAA_0001);
      check_eq("first_blocked", 32'(s_blk), 32'd0);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, 1, 0);
      check_eq("stall_no_req", 32'(s_rv), 32'd0);
      check_eq("stall_out_pc", s_fpc, 32'h0);
      step(0, 0, 0, 0, 1, 1, 0);
      step(0, 1, 0, 0, 1, 1, 0);
      check_eq("drain_pc", s_fpc, 32'h4);
      check_eq("drain_valid", 32'(s_fv), 32'd1);

      // Redirect while waiting for 0x10.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(0, 0, 0, 0, 1, 2, 0);
         if (acc && acc_addr == 32'h10) found = 1'b1;
      end
      check_eq("reach_0x10", 32'(found), 32'd1);
      step(0, 0, 1, 32'h100, 1, 2, 0);
      found  = 1'b0;
      seen10 = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(0, 0, 0, 0, 1, 1, 0);
         if (s_fv && s_fpc == 32'h10) seen10 = 1'b1;
         if (acc) found = 1'b1;
      end
      check_eq("redir_req_seen", 32'(found), 32'd1);
      check_eq("redir_req_addr", acc_addr, 32'h100);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 1, 1, 0);
         if (s_fv && s_fpc == 32'h10) seen10 = 1'b1;
      end
      check_eq("no_pc_0x10", 32'(seen10), 32'd0);

      // Redirect coincident with the response, then ready low for 3 cycles.
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(0, 0, 0, 0, 1, 1, 0);
         if (acc) found = 1'b1;
      end
      check_eq("pre_branch_acc", 32'(found), 32'd1);
      step(0, 0, 1, 32'h200, 1, 1, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      check_eq("same_cyc_req", 32'(s_rv), 32'd1);
      check_eq("same_cyc_addr", s_ra, 32'h200);
      first_addr = s_ra;
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      check_eq("rdy_low_valid", 32'(s_rv), 32'd1);
      check_eq("rdy_low_addr", s_ra, first_addr);
      step(0, 0, 0, 0, 1, 1, 0);
      check_eq("rdy_accept", 32'(acc), 32'd1);
      check_eq("rdy_accept_addr", acc_addr, 32'h200);

      // Address wrap past the top of the address space.
      step(0, 0, 1, 32'hFFFF_FFFC, 1, 1, 0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(0, 0, 0, 0, 1, 1, 0);
         if (acc && acc_addr == 32'h0) found = 1'b1;
      end
      check_eq("wrap_to_zero", 32'(found), 32'd1);

      // Reset while waiting; stale response arrives right after release.
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 1, 0);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(0, 0, 0, 0, 1, 3, 0);
         if (acc) found = 1'b1;
      end
      check_eq("pre_reset_acc", 32'(found), 32'd1);
      step(1, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1, 1);
      check_eq("post_rst_req", 32'(s_rv), 32'd1);
      step(0, 0, 0, 0, 0, 1, 0);
      check_eq("stale_ignored", 32'(s_fv), 32'd0);
      step(0, 0, 0, 0, 1, 1, 0);
      check_eq("post_rst_acc", 32'(acc), 32'd1);
      check_eq("post_rst_addr", acc_addr, RST_PC);
      step(0, 1, 0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0, 1, 0);
      check_eq("post_rst_out_pc", s_fpc, RST_PC);
      check_eq("post_rst_out_instr", s_fi, mem_word(RST_PC));

      // Randomized traffic against the stream model.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 600) == 0,
              ($urandom % 10) < 3,
              ($urandom % 20) == 0,
              32'($urandom_range(0, 1023)) << 2,
              ($urandom % 10) < 7,
              int'($urandom_range(1, 3)),
              1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_instruction_fetch_controller
